shift_seq: RTL and testbench
============================

// Module: shift_seq
// PURPOSE
//  Multi-cycle shift/rotate execution unit, one stage upstream of the 8-register file.
//  Accepts an operand, shift op, amount and destination register; shifts one bit per cycle.
//  Drives a one-cycle write request: result, destination address, zero/negative/shift-carry flags.
//  The request goes straight onto the register-file dat_in/wr_en/wr_addr/flag inputs.
// PARAMETERS
//  W   8  datapath width (bits)
//  PW  3  register address pointer width
//  CW  3  shift-amount width; max amount 2**CW-1
// PORTS
//  clk       in   1   clock; all state changes on rising edge
//  reset     in   1   asynchronous, active-low reset
//  start     in   1   request; sampled only when busy==0
//  op        in   2   0=LSL 1=LSR 2=ASR 3=ROL
//  dat_in    in   W   operand
//  amt       in   CW  shift amount
//  dst_addr  in   PW  destination register
//  busy      out  1   high in SHIFT and WB states
//  wr_en     out  1   one-cycle write strobe to register file
//  wr_addr   out  PW  destination register of last result
//  dat_out   out  W   last result
//  zeroOut   out  1   dat_out==0
//  ngtvOut   out  1   dat_out[W-1]
//  scryOut   out  1   last bit shifted/rotated out
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; busy, wr_en, wr_addr, dat_out, all flags = 0.
//  States: IDLE, SHIFT, WB.
//  IDLE: start at edge E0 latches op, dat_in, amt (counter), dst_addr.
//   amt>0 -> SHIFT. amt==0 -> WB; result=dat_in, scry=0.
//  SHIFT: one 1-bit step per edge; counter decrements each step.
//   The edge performing step amt (E_amt) -> WB.
//  Per step: LSL {x[W-2:0],0}, c=x[W-1]. LSR {0,x[W-1:1]}, c=x[0].
//   ASR {x[W-1],x[W-1:1]}, c=x[0]. ROL {x[W-2:0],x[W-1]}, c=x[W-1].
//   c from final step becomes scryOut.
//  WB: wr_en=1 for exactly one cycle (cycle after E_amt); register file writes at E_amt+1.
//   Then -> IDLE.
//  dat_out, wr_addr and flags are registered together on WB entry.
//   They hold until next WB entry or reset.
//  Latency: start edge to wr_en rising = amt+1 edges counting E0 (amt==0 -> 1 cycle).
//  start while busy==1 (incl. WB cycle) ignored, no queuing.
//  Operands latched at E0; later dat_in/amt/op changes do not affect the op.
//  Reset mid-SHIFT/WB: operation abandoned; no wr_en pulse, outputs return to 0.
//  Flags derive from the final W-bit result only; no wider intermediate width.
// STRUCTURE
//  Shared package cpu_pkg:
//   - shift_op_t enum (LSL/LSR/ASR/ROL)
//   - shstate_t enum (IDLE/SHIFT/WB)
//   - function shift1(op, x) returning {c, x'}
//  No sub-module: one state register, one counter, one operand register, one output register set.
// TESTING
//  1. LSL dat_in=8'h81 amt=1 dst=3 -> wr_en one cycle at E1: dat_out=8'h02, wr_addr=3, scry=1 zero=0 ngtv=0.
//  2. ASR 8'h80 amt=7 -> wr_en at E7: dat_out=8'hFF, ngtv=1, scry=0; busy high E0..E8.
//  3. LSR 8'h01 amt=1 -> dat_out=8'h00, zero=1, scry=1.
//  4. ROL 8'hA5 amt=3 -> dat_out=8'h2D, scry=1.
//   Second start during SHIFT is ignored: exactly one wr_en.
//  5. amt=0 dat_in=8'h5A -> wr_en in cycle after E0: dat_out=8'h5A, scry=0.
//   Outputs hold 8'h5A with wr_en low afterwards.
//  6. LSL amt=5, reset low mid-SHIFT -> immediately busy=0, dat_out=0, flags=0.
//   No wr_en pulse; after reset release a new start works normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the shift/rotate execution unit.
package cpu_pkg;

    // Default datapath geometry; the shift helper below is sized to DATA_W.
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned AMT_W  = 3;

    typedef enum logic [1:0] {
        OP_LSL = 2'd0,
        OP_LSR = 2'd1,
        OP_ASR = 2'd2,
        OP_ROL = 2'd3
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WB    = 2'd2
    } shstate_t;

    // One single-bit step: returns {bit shifted/rotated out, shifted value}.
    function automatic logic [DATA_W:0] shift1(input shift_op_t op, input logic [DATA_W-1:0] x);
        logic [DATA_W:0] r;
        r = '0;
        case (op)
            OP_LSL:  r = {x[DATA_W-1], x[DATA_W-2:0], 1'b0};
            OP_LSR:  r = {x[0], 1'b0, x[DATA_W-1:1]};
            OP_ASR:  r = {x[0], x[DATA_W-1], x[DATA_W-1:1]};
            OP_ROL:  r = {x[DATA_W-1], x[DATA_W-2:0], x[DATA_W-1]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate unit: one bit per cycle, then a one-cycle
// write request to the register file with result flags.
module shift_seq
    import cpu_pkg::*;
#(
    // W must match cpu_pkg::DATA_W because the step helper is sized to it.
    parameter int unsigned W  = DATA_W,
    parameter int unsigned PW = ADDR_W,
    parameter int unsigned CW = AMT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [W-1:0]  dat_in,
    input  logic [CW-1:0] amt,
    input  logic [PW-1:0] dst_addr,
    output logic          busy,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr,
    output logic [W-1:0]  dat_out,
    output logic          zeroOut,
    output logic          ngtvOut,
    output logic          scryOut
);

    shstate_t      state_q, state_d;
    shift_op_t     op_q, op_d;
    logic [W-1:0]  opr_q, opr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] dst_q, dst_d;

    logic [W-1:0]  dat_out_q, dat_out_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic          zero_q, zero_d;
    logic          ngtv_q, ngtv_d;
    logic          scry_q, scry_d;

    logic          load;
    logic [W-1:0]  load_dat;
    logic          load_scry;
    logic [W:0]    step;

    assign step = shift1(op_q, opr_q);

    // Next-state, operand/counter update and output-register load on WB entry.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        op_d      = op_q;
        opr_d     = opr_q;
        cnt_d     = cnt_q;
        dst_d     = dst_q;
        load      = 1'b0;
        load_dat  = opr_q;
        load_scry = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = shift_op_t'(op);
                    opr_d = dat_in;
                    cnt_d = amt;
                    dst_d = dst_addr;
                    if (amt == '0) begin
                        // Zero-length op: pass the operand straight through, no carry.
                        state_d   = ST_WB;
                        load      = 1'b1;
                        load_dat  = dat_in;
                        load_scry = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                opr_d = step[W-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Final step: its result and carry go directly into the outputs.
                    state_d   = ST_WB;
                    load      = 1'b1;
                    load_dat  = step[W-1:0];
                    load_scry = step[W];
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Result registers only change on WB entry and hold otherwise.
        dat_out_d = load ? load_dat  : dat_out_q;
        wr_addr_d = load ? (state_q == ST_IDLE ? dst_addr : dst_q) : wr_addr_q;
        zero_d    = load ? (load_dat == '0) : zero_q;
        ngtv_d    = load ? load_dat[W-1]    : ngtv_q;
        scry_d    = load ? load_scry        : scry_q;
    end

    // State, working registers and result registers; all cleared by async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LSL;
            opr_q     <= '0;
            cnt_q     <= '0;
            dst_q     <= '0;
            dat_out_q <= '0;
            wr_addr_q <= '0;
            zero_q    <= 1'b0;
            ngtv_q    <= 1'b0;
            scry_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            op_q      <= op_d;
            opr_q     <= opr_d;
            cnt_q     <= cnt_d;
            dst_q     <= dst_d;
            dat_out_q <= dat_out_d;
            wr_addr_q <= wr_addr_d;
            zero_q    <= zero_d;
            ngtv_q    <= ngtv_d;
            scry_q    <= scry_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign wr_en   = (state_q == ST_WB);
    assign wr_addr = wr_addr_q;
    assign dat_out = dat_out_q;
    assign zeroOut = zero_q;
    assign ngtvOut = ngtv_q;
    assign scryOut = scry_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: driver pushes expected write requests,
// a monitor pops and compares whenever wr_en is seen.
module tb_shift_seq;

    localparam int W  = 8;
    localparam int PW = 3;
    localparam int CW = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  dat_in;
    logic [CW-1:0] amt;
    logic [PW-1:0] dst_addr;
    logic          busy;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [W-1:0]  dat_out;
    logic          zeroOut;
    logic          ngtvOut;
    logic          scryOut;

    shift_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dat_in   (dat_in),
        .amt      (amt),
        .dst_addr (dst_addr),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .dat_out  (dat_out),
        .zeroOut  (zeroOut),
        .ngtvOut  (ngtvOut),
        .scryOut  (scryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic [PW-1:0] addr;
        logic          zero;
        logic          ngtv;
        logic          scry;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole multi-bit shift at once, plain arithmetic.
    function automatic exp_t model(input int o, input int x, input int a, input int dst);
        exp_t e;
        int   r;
        int   c;
        logic signed [W-1:0] sx;
        r = 0;
        c = 0;
        case (o)
            0: begin
                r = (x << a) & 'hFF;
                c = (a > 0) ? ((x >> (W - a)) & 1) : 0;
            end
            1: begin
                r = x >> a;
                c = (a > 0) ? ((x >> (a - 1)) & 1) : 0;
            end
            2: begin
                sx = W'(x);
                r  = int'(W'(sx >>> a));
                c  = (a > 0) ? ((x >> (a - 1)) & 1) : 0;
            end
            default: begin
                r = ((x << a) | (x >> (W - a))) & 'hFF;
                c = (a > 0) ? (r & 1) : 0;
            end
        endcase
        e.data = W'(r);
        e.addr = PW'(dst);
        e.zero = (r == 0);
        e.ngtv = r[W-1];
        e.scry = c[0];
        e.cyc  = 0;
        return e;
    endfunction

    // Monitor: every wr_en cycle must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset && wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr_en", 32'(wr_en), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dat_out", 32'(dat_out), 32'(e.data));
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("zeroOut", 32'(zeroOut), 32'(e.zero));
                check("ngtvOut", 32'(ngtvOut), 32'(e.ngtv));
                check("scryOut", 32'(scryOut), 32'(e.scry));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one operation; optionally keep start asserted with junk while busy.
    task automatic do_op(input int o, input int x, input int a, input int dst, input bit hold);
        exp_t e;
        int   nbusy;
        bit   done;
        e     = model(o, x, a, dst);
        e.cyc = cyc + 1 + a;
        exp_q.push_back(e);
        start    = 1'b1;
        op       = 2'(o);
        dat_in   = W'(x);
        amt      = CW'(a);
        dst_addr = PW'(dst);
        nbusy    = 0;
        done     = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            // Operands change after E0; the latched op must not be affected.
            start    = hold;
            op       = 2'($urandom);
            dat_in   = W'($urandom);
            amt      = CW'($urandom);
            dst_addr = PW'($urandom);
            if (busy) nbusy++;
            else begin
                done  = 1;
                start = 1'b0;
            end
        end
        if (!done) check("busy_timeout", 32'd1, 32'd0);
        check("busy_cycles", 32'(nbusy), 32'(a + 1));
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        op       = '0;
        dat_in   = '0;
        amt      = '0;
        dst_addr = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_outputs", 32'({wr_addr, dat_out, zeroOut, ngtvOut, scryOut}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_op(0, 'h81, 1, 3, 0);
        do_op(2, 'h80, 7, 5, 0);
        do_op(1, 'h01, 1, 1, 0);
        do_op(3, 'hA5, 3, 6, 1);
        do_op(0, 'h5A, 0, 2, 1);
        do_op(1, 'h5A, 0, 4, 0);
        repeat (3) begin
            @(negedge clk);
            check("hold_dat_out", 32'(dat_out), 32'h5A);
            check("hold_wr_en", 32'(wr_en), 32'd0);
        end

        // Reset mid-SHIFT: op abandoned, outputs cleared, no write pulse.
        do_op(0, 'hFF, 7, 7, 0);
        start    = 1'b1;
        op       = 2'd0;
        dat_in   = 8'h33;
        amt      = 3'd5;
        dst_addr = 3'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_outputs", 32'({wr_addr, dat_out, zeroOut, ngtvOut, scryOut}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        do_op(0, 'h33, 5, 2, 0);

        for (int k = 0; k < 40; k++) begin
            do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
